three_phase_deadtime: RTL
=========================

THREE_PHASE_DEADTIME -- requirements
Module: three_phase_deadtime

Interface
REQ-001 SHALL have parameter: deadtime_width, 8, width of dead-time count.
REQ-002 SHALL have port: aclk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  1 = bridge switching allowed.
REQ-005 SHALL have port: deadtime  input  deadtime_width  dead-time in aclk cycles, unsigned.
REQ-006 SHALL have port: pwm_a / pwm_b / pwm_c  input  1 each  per-phase PWM from three_phase_modulator, synchronous to aclk.
REQ-007 SHALL have port: fault  input  1  external overcurrent/driver fault, active-high.
REQ-008 SHALL have port: fault_clear  input  1  single-cycle pulse that clears the latched fault.
REQ-009 SHALL have port: a_h, a_l, b_h, b_l, c_h, c_l  output  1 each  high-side and low-side gate commands.
REQ-010 SHALL have port: fault_latched  output  1  sticky fault flag.

Function
REQ-011 Each phase SHALL run an independent FSM with states OFF, LOW, DEAD, HIGH; x_h=1 only in HIGH, x_l=1 only in LOW, both 0 in OFF and DEAD.
REQ-012 Gate outputs SHALL be driven directly by flip-flops (no combinational decode) so they are glitch-free.
REQ-013 OFF -> DEAD when enable=1 and fault_latched=0; counter loaded with deadtime, target := pwm_x.
REQ-014 DEAD: target follows pwm_x every cycle; counter decrements; when counter==0 the next state is HIGH if target=1, else LOW. Counter SHALL NOT be reloaded while in DEAD.
REQ-015 LOW -> DEAD when pwm_x=1; HIGH -> DEAD when pwm_x=0; counter loaded with deadtime on that edge.
REQ-016 Latency: pwm_x first sampled at new value on edge N -> active gate drops after edge N, opposite gate rises after edge N+deadtime+1 (both-off interval = deadtime+1 cycles; deadtime=0 gives exactly 1 cycle).
REQ-017 Input pulses shorter than the dead interval SHALL be absorbed: the phase exits DEAD to the level of pwm_x sampled at exit.
REQ-018 deadtime changes SHALL take effect only at the next counter load.
REQ-019 enable=0 or fault_latched=1 SHALL force every phase to OFF on the next edge, overriding all other transitions.
REQ-020 fault_latched SHALL set on any edge with fault=1; it SHALL clear only on an edge with fault_clear=1 and fault=0; simultaneous fault and fault_clear -> stays set.
REQ-021 x_h and x_l SHALL never both be 1 on any cycle, for any input sequence.

Reset
REQ-022 reset=1 SHALL immediately (asynchronously) force all gate outputs to 0, all FSMs to OFF, counters to 0, fault_latched to 1.
REQ-023 After reset release, switching SHALL begin only after fault_clear with fault=0 and enable=1, passing through a full DEAD interval.

Structure
REQ-024 FSM state encodings and the default deadtime_width SHALL live in the shared motor-control package.
REQ-025 Per-phase logic SHALL be a sub-module deadtime_phase, instantiated three times; fault latch lives in the top.

Verification (aclk 100 MHz, deadtime=10 unless stated)
REQ-026 Reset asserted mid-HIGH on phase a -> a_h=0 without waiting for an aclk edge; all outputs 0, fault_latched=1.
REQ-027 fault_clear, enable=1, pwm_a=0 steady -> a_h=a_l=0 for 11 cycles, then a_l=1.
REQ-028 pwm_a 0->1 first sampled at edge 100 -> a_l=0 after edge 100, a_h=1 after edge 111; repeat 1->0 symmetric; deadtime=0 -> 1-cycle gap.
REQ-029 From LOW, pwm_a high for 5 cycles -> a_h never asserts, a_l reasserts after edge N+11.
REQ-030 fault=1 while phases in HIGH/LOW -> all gates 0 after next edge; fault_clear with fault=1 ignored; fault_clear after fault=0 -> re-entry via 11-cycle DEAD.
REQ-031 Random pwm_a/b/c, deadtime and enable for 1e6 cycles -> assertion x_h&x_l never true and every gap between opposite gates is >= deadtime+1 cycles.

Source files
------------

// File: rtl/three_phase_deadtime_pkg.sv
// Shared motor-control definitions for the three-phase dead-time generator.
//   DeadtimeWidthDefault : default width of the dead-time count
//   phase_state_e        : per-phase gate FSM state encoding
package three_phase_deadtime_pkg;

    localparam int unsigned DeadtimeWidthDefault = 8;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StLow  = 2'd1,
        StDead = 2'd2,
        StHigh = 2'd3
    } phase_state_e;

endpackage

// File: rtl/three_phase_deadtime_phase.sv
// One bridge leg: turns a PWM level into complementary high/low gate commands
// with a guaranteed both-off interval of deadtime+1 cycles between them.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, forces OFF with gates low
//   kill_i     : forces OFF on the next edge, overrides every other transition
//   deadtime_i : dead-time in clock cycles, sampled only when the counter loads
//   pwm_i      : requested leg level
//   gate_h_o   : high-side gate command (registered)
//   gate_l_o   : low-side gate command (registered)
module deadtime_phase
    import three_phase_deadtime_pkg::*;
#(
    parameter int unsigned Width = DeadtimeWidthDefault
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic [Width-1:0] deadtime_i,
    input  logic             pwm_i,
    output logic             gate_h_o,
    output logic             gate_l_o
);

    phase_state_e     state_q;
    logic [Width-1:0] count_q;

    // Gate outputs are flops written alongside the state so they never glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StOff;
            count_q  <= '0;
            gate_h_o <= 1'b0;
            gate_l_o <= 1'b0;
        end else if (kill_i) begin
            state_q  <= StOff;
            count_q  <= '0;
            gate_h_o <= 1'b0;
            gate_l_o <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_q  <= StDead;
                    count_q  <= deadtime_i;
                    gate_h_o <= 1'b0;
                    gate_l_o <= 1'b0;
                end
                StLow: begin
                    if (pwm_i) begin
                        state_q  <= StDead;
                        count_q  <= deadtime_i;
                        gate_l_o <= 1'b0;
                    end
                end
                StHigh: begin
                    if (!pwm_i) begin
                        state_q  <= StDead;
                        count_q  <= deadtime_i;
                        gate_h_o <= 1'b0;
                    end
                end
                StDead: begin
                    // The target level is simply the PWM seen on the exit edge,
                    // so pulses shorter than the dead interval vanish.
                    if (count_q == '0) begin
                        if (pwm_i) begin
                            state_q  <= StHigh;
                            gate_h_o <= 1'b1;
                        end else begin
                            state_q  <= StLow;
                            gate_l_o <= 1'b1;
                        end
                    end else begin
                        count_q <= count_q - Width'(1);
                    end
                end
                default: begin
                    state_q  <= StOff;
                    count_q  <= '0;
                    gate_h_o <= 1'b0;
                    gate_l_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/three_phase_deadtime.sv
// Three-phase dead-time generator with sticky fault latch.
//   aclk          : clock, rising edge
//   reset         : asynchronous active-high reset; gates off, fault latched
//   enable        : 1 allows bridge switching
//   deadtime      : dead-time in aclk cycles
//   pwm_a/b/c     : per-phase PWM levels
//   fault         : external fault, active-high
//   fault_clear   : pulse that clears the latched fault (ignored while fault=1)
//   a_h..c_l      : high/low gate commands per phase
//   fault_latched : sticky fault flag
module three_phase_deadtime
    import three_phase_deadtime_pkg::*;
#(
    parameter int unsigned deadtime_width = DeadtimeWidthDefault
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [deadtime_width-1:0] deadtime,
    input  logic                      pwm_a,
    input  logic                      pwm_b,
    input  logic                      pwm_c,
    input  logic                      fault,
    input  logic                      fault_clear,
    output logic                      a_h,
    output logic                      a_l,
    output logic                      b_h,
    output logic                      b_l,
    output logic                      c_h,
    output logic                      c_l,
    output logic                      fault_latched
);

    logic kill;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            fault_latched <= 1'b1;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clear) begin
            fault_latched <= 1'b0;
        end
    end

    // The raw fault input is included so gates drop on the same edge that
    // latches the fault rather than one cycle later.
    assign kill = ~enable | fault_latched | fault;

    deadtime_phase #(
        .Width(deadtime_width)
    ) u_phase_a (
        .clk_i     (aclk),
        .rst_i     (reset),
        .kill_i    (kill),
        .deadtime_i(deadtime),
        .pwm_i     (pwm_a),
        .gate_h_o  (a_h),
        .gate_l_o  (a_l)
    );

    deadtime_phase #(
        .Width(deadtime_width)
    ) u_phase_b (
        .clk_i     (aclk),
        .rst_i     (reset),
        .kill_i    (kill),
        .deadtime_i(deadtime),
        .pwm_i     (pwm_b),
        .gate_h_o  (b_h),
        .gate_l_o  (b_l)
    );

    deadtime_phase #(
        .Width(deadtime_width)
    ) u_phase_c (
        .clk_i     (aclk),
        .rst_i     (reset),
        .kill_i    (kill),
        .deadtime_i(deadtime),
        .pwm_i     (pwm_c),
        .gate_h_o  (c_h),
        .gate_l_o  (c_l)
    );

endmodule
